// File: rtl/bank_cfg_ctrl.sv
// Configuration sequencer: assembles one bitline row from a word stream, drives it on bl_out,
// then pulses the matching one-hot wordline, once for every row of the tile.
module bank_cfg_ctrl #(
    parameter int unsigned BL_W      = 315,
    parameter int unsigned WL_W      = 4,
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned SETUP_CYC = 2,
    parameter int unsigned PULSE_CYC = 3
) (
    input  logic              prog_clk,
    input  logic              pReset,
    input  logic              start,
    input  logic [DATA_W-1:0] cfg_data,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    output logic [BL_W-1:0]   bl_out,
    output logic [WL_W-1:0]   wl_out,
    output logic              busy,
    output logic              done
);
    localparam int unsigned WPR  = (BL_W + DATA_W - 1) / DATA_W;
    localparam int unsigned WCW  = (WPR > 1) ? $clog2(WPR) : 1;
    localparam int unsigned RCW  = $clog2(WL_W);
    localparam int unsigned TMAX = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
    localparam int unsigned TCW  = (TMAX > 1) ? $clog2(TMAX) : 1;

    localparam logic [WCW-1:0] WordLast  = WCW'(WPR - 1);
    localparam logic [RCW-1:0] RowLast   = RCW'(WL_W - 1);
    localparam logic [TCW-1:0] SetupLast = TCW'(SETUP_CYC - 1);
    localparam logic [TCW-1:0] PulseLast = TCW'(PULSE_CYC - 1);

    typedef enum logic [2:0] {
        StIdle, StLoad, StSetup, StPulse, StHold, StDone
    } state_e;

    state_e                  state_q, state_d;
    logic [WCW-1:0]          wcnt_q, wcnt_d;
    logic [RCW-1:0]          row_q, row_d;
    logic [TCW-1:0]          tcnt_q, tcnt_d;
    logic [WPR*DATA_W-1:0]   rowreg_q, rowreg_d;
    logic [BL_W-1:0]         bl_d;
    logic [WL_W-1:0]         wl_d;
    logic                    accept;

    assign cfg_ready = (state_q == StLoad);
    assign accept    = cfg_valid && cfg_ready;
    assign busy      = (state_q != StIdle);
    assign done      = (state_q == StDone);

    always_comb begin
        state_d  = state_q;
        wcnt_d   = wcnt_q;
        row_d    = row_q;
        tcnt_d   = tcnt_q;
        rowreg_d = rowreg_q;
        bl_d     = bl_out;
        wl_d     = '0;

        if (accept) begin
            for (int k = 0; k < WPR; k++) begin
                if (wcnt_q == WCW'(k)) rowreg_d[k*DATA_W +: DATA_W] = cfg_data;
            end
        end

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StLoad;
                    wcnt_d  = '0;
                    row_d   = '0;
                end
            end
            StLoad: begin
                if (accept) begin
                    if (wcnt_q == WordLast) begin
                        state_d = StSetup;
                        tcnt_d  = '0;
                    end else begin
                        wcnt_d = wcnt_q + 1'b1;
                    end
                end
            end
            StSetup: begin
                if (tcnt_q == SetupLast) begin
                    state_d = StPulse;
                    tcnt_d  = '0;
                end else begin
                    tcnt_d = tcnt_q + 1'b1;
                end
            end
            StPulse: begin
                if (tcnt_q == PulseLast) begin
                    state_d = StHold;
                    tcnt_d  = '0;
                end else begin
                    tcnt_d = tcnt_q + 1'b1;
                end
            end
            StHold: begin
                row_d = row_q + 1'b1;
                if (row_q == RowLast) begin
                    state_d = StDone;
                end else begin
                    state_d = StLoad;
                    wcnt_d  = '0;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase

        // Capture includes the word accepted on this very edge; words beyond BL_W drop here.
        if (state_q == StLoad && state_d == StSetup) begin
            bl_d = rowreg_d[BL_W-1:0];
        end else if (!(state_d inside {StSetup, StPulse, StHold})) begin
            bl_d = '0;
        end

        if (state_d == StPulse) wl_d = WL_W'(1) << row_q;
    end

    always_ff @(posedge prog_clk) begin
        if (pReset) begin
            state_q  <= StIdle;
            wcnt_q   <= '0;
            row_q    <= '0;
            tcnt_q   <= '0;
            rowreg_q <= '0;
            bl_out   <= '0;
            wl_out   <= '0;
        end else begin
            state_q  <= state_d;
            wcnt_q   <= wcnt_d;
            row_q    <= row_d;
            tcnt_q   <= tcnt_d;
            rowreg_q <= rowreg_d;
            bl_out   <= bl_d;
            wl_out   <= wl_d;
        end
    end

endmodule

// File: tb/tb_bank_cfg_ctrl.sv
// Directed bench for bank_cfg_ctrl: default instance plus a small-parameter instance.
module tb_bank_cfg_ctrl;
    localparam int WPR = 20;

    logic         prog_clk = 1'b0;
    logic         pReset   = 1'b1;
    logic         start    = 1'b0;
    logic         cfg_valid = 1'b0;
    logic [15:0]  cfg_data = '0;
    logic         cfg_ready, busy, done;
    logic [314:0] bl_out;
    logic [3:0]   wl_out;

    logic         s_start = 1'b0;
    logic         s_valid = 1'b0;
    logic [15:0]  s_data  = '0;
    logic         s_ready, s_busy, s_done;
    logic [31:0]  s_bl;
    logic [1:0]   s_wl;

    int errors = 0;
    int checks = 0;
    int viol = 0;
    int done_cnt = 0;
    int load_wl_hits = 0;
    logic [314:0] bl_prev = '0;

    always #5 prog_clk = ~prog_clk;

    bank_cfg_ctrl dut (
        .prog_clk (prog_clk),
        .pReset   (pReset),
        .start    (start),
        .cfg_data (cfg_data),
        .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready),
        .bl_out   (bl_out),
        .wl_out   (wl_out),
        .busy     (busy),
        .done     (done)
    );

    bank_cfg_ctrl #(
        .BL_W     (32),
        .WL_W     (2),
        .DATA_W   (16),
        .SETUP_CYC(1),
        .PULSE_CYC(1)
    ) dut_s (
        .prog_clk (prog_clk),
        .pReset   (pReset),
        .start    (s_start),
        .cfg_data (s_data),
        .cfg_valid(s_valid),
        .cfg_ready(s_ready),
        .bl_out   (s_bl),
        .wl_out   (s_wl),
        .busy     (s_busy),
        .done     (s_done)
    );

    // Whole-run invariants: one-hot wordline, bitlines stable while a wordline is up.
    always @(negedge prog_clk) begin
        if (!$onehot0(wl_out)) viol++;
        if (wl_out != '0 && (bl_out != bl_prev || bl_out == '0)) viol++;
        if (done) done_cnt++;
        bl_prev = bl_out;
    end

    task automatic check_val(input string tag, input logic [319:0] got, input logic [319:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge prog_clk);
        #1;
    endtask

    function automatic logic [15:0] word(input int r, input int k);
        return {r[3:0], k[11:0]};
    endfunction

    function automatic logic [319:0] exp_row(input int r);
        logic [319:0] v = '0;
        for (int k = 0; k < WPR; k++) v[k*16 +: 16] = word(r, k);
        v[319:315] = '0;
        return v;
    endfunction

    // mode 0: continuous valid, 1: valid on odd cycles only, 2: random gaps
    task automatic feed_words(input int r, input int mode, output int cyc);
        int   k = 0;
        logic v;
        cyc = 0;
        while (k < WPR && cyc < 400) begin
            case (mode)
                0:       v = 1'b1;
                1:       v = cyc[0];
                default: v = 1'($urandom_range(0, 1));
            endcase
            cfg_valid = v;
            cfg_data  = v ? word(r, k) : 16'hbeef;
            if (wl_out != '0) load_wl_hits++;
            if (v && cfg_ready) k++;
            step();
            cyc++;
        end
        cfg_valid = 1'b0;
        if (cyc >= 400) check_val("load_timeout", cyc, 0);
    endtask

    // Six cycles after the last word: SETUP x2, PULSE x3, HOLD x1.
    task automatic check_tail(input int r, input bit junk);
        logic [319:0] e = exp_row(r);
        for (int c = 0; c < 6; c++) begin
            cfg_valid = junk;
            cfg_data  = 16'hbad0;
            if (junk) start = (c == 2);
            check_val($sformatf("bl_r%0d_c%0d", r, c), bl_out, e);
            check_val($sformatf("wl_r%0d_c%0d", r, c), wl_out,
                      (c >= 2 && c < 5) ? (320'd1 << r) : 320'd0);
            step();
        end
        cfg_valid = 1'b0;
        if (junk) start = 1'b0;
    endtask

    task automatic run_pass(input int mode, input bit junk);
        int cyc;
        for (int r = 0; r < 4; r++) begin
            feed_words(r, mode, cyc);
            if (mode == 0) check_val($sformatf("load_cyc_r%0d", r), cyc, 20);
            if (mode == 1) check_val($sformatf("bp_load_cyc_r%0d", r), cyc, 40);
            check_tail(r, junk);
        end
        check_val("done_pulse", done, 1);
        check_val("wl_in_load", load_wl_hits, 0);
    endtask

    initial begin
        int cyc;
        int d0;
        int lat;

        repeat (3) step();
        check_val("rst_busy", busy, 0);
        check_val("rst_done", done, 0);
        check_val("rst_ready", cfg_ready, 0);
        check_val("rst_bl", bl_out, 0);
        check_val("rst_wl", wl_out, 0);

        // Reset beats start in the same cycle
        start = 1'b1;
        step();
        check_val("start_vs_reset", busy, 0);
        pReset = 1'b0;
        start  = 1'b0;
        step();
        check_val("still_idle", busy, 0);

        // Full pass with start held high throughout: exact 105-cycle latency, auto-restart
        start = 1'b1;
        step();
        check_val("ready_after_start", cfg_ready, 1);
        run_pass(0, 1'b0);
        check_val("busy_in_done", busy, 1);
        step();
        check_val("idle_after_done", busy, 0);
        check_val("done_one_cycle", done, 0);
        step();
        check_val("restart_busy", busy, 1);
        check_val("restart_ready", cfg_ready, 1);
        start  = 1'b0;
        pReset = 1'b1;
        step();
        pReset = 1'b0;

        // Backpressure: valid on alternate cycles
        start = 1'b1;
        step();
        start = 1'b0;
        run_pass(1, 1'b0);
        step();

        // Ignored start/valid outside LOAD, then valid high while idle
        start = 1'b1;
        step();
        start = 1'b0;
        run_pass(0, 1'b1);
        step();
        cfg_valid = 1'b1;
        cfg_data  = 16'hdead;
        repeat (3) step();
        check_val("no_extra_pass", busy, 0);
        start = 1'b1;
        step();
        start = 1'b0;
        run_pass(0, 1'b0);
        step();

        // Reset during row 2's pulse, then a fresh pass must begin at row 0
        start = 1'b1;
        step();
        start = 1'b0;
        feed_words(0, 0, cyc);
        check_tail(0, 1'b0);
        feed_words(1, 0, cyc);
        check_tail(1, 1'b0);
        feed_words(2, 0, cyc);
        step();
        step();
        check_val("pulse_row2", wl_out, 4'b0100);
        pReset = 1'b1;
        step();
        check_val("rst_drops_wl", wl_out, 0);
        step();
        step();
        pReset = 1'b0;
        check_val("mid_rst_wl", wl_out, 0);
        check_val("mid_rst_bl", bl_out, 0);
        check_val("mid_rst_busy", busy, 0);
        check_val("mid_rst_done", done, 0);
        check_val("mid_rst_ready", cfg_ready, 0);
        start = 1'b1;
        step();
        start = 1'b0;
        run_pass(0, 1'b0);
        step();

        // Random valid gaps over 20 passes
        d0 = done_cnt;
        for (int p = 0; p < 20; p++) begin
            start = 1'b1;
            step();
            start = 1'b0;
            run_pass(2, 1'b0);
            step();
        end
        check_val("done_count", done_cnt - d0, 20);

        // Small-parameter instance: WPR=2, 5 cycles per row, done at +11
        s_valid = 1'b1;
        s_start = 1'b1;
        step();
        s_start = 1'b0;
        lat = 0;
        for (int i = 1; i <= 13; i++) begin
            s_data = 16'ha000 + i[15:0];
            if (i == 3) check_val("s_bl_r0", s_bl, 32'ha002a001);
            if (i == 4) check_val("s_wl_r0", s_wl, 2'b01);
            if (i == 8) check_val("s_bl_r1", s_bl, 32'ha007a006);
            if (i == 9) check_val("s_wl_r1", s_wl, 2'b10);
            if (s_done && lat == 0) lat = i;
            step();
        end
        s_valid = 1'b0;
        check_val("s_done_latency", lat, 11);

        check_val("wl_invariants", viol, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
